// File: rtl/vec_lsu.sv
// vec_lsu: single-outstanding vector load/store unit moving one 16-word
// (512-bit) vector between word-addressed memory and the vector register file.
// Optional feature macro: LSU_BOUNDS_CHECK_EN -- when defined, commands whose
// base address would run past the end of memory (cmd_addr > 496) complete
// immediately with resp_err=1 and touch neither memory nor the register file.
module vec_lsu #(
  parameter int VREG_AW = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_op,
  input  logic [8:0]         cmd_addr,
  input  logic [VREG_AW-1:0] cmd_vreg,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_err,
  output logic               mem_read_enable,
  output logic               mem_write_enable,
  output logic [8:0]         mem_read_address,
  output logic [8:0]         mem_write_address,
  output logic [511:0]       mem_data,
  input  logic [511:0]       mem_out,
  output logic               vrf_re,
  output logic [VREG_AW-1:0] vrf_raddr,
  input  logic [511:0]       vrf_rdata,
  output logic               vrf_we,
  output logic [VREG_AW-1:0] vrf_waddr,
  output logic [511:0]       vrf_wdata,
  output logic [15:0]        done_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD_REQ = 3'd1,
    LD_WB  = 3'd2,
    ST_RD  = 3'd3,
    ST_WR  = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic                 op_q, op_d;
  logic [8:0]           addr_q, addr_d;
  logic [VREG_AW-1:0]   vreg_q, vreg_d;
  logic [511:0]         rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [15:0]          done_count_q, done_count_d;
  logic                 oob_s;

  // Out-of-range detection: a 16-word vector starting above 496 would wrap.
`ifdef LSU_BOUNDS_CHECK_EN
  assign oob_s = (cmd_addr > 9'd496);
`else
  assign oob_s = 1'b0;
`endif

  // State register and command/data holding registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      op_q         <= 1'b0;
      addr_q       <= 9'd0;
      vreg_q       <= '0;
      rdata_q      <= 512'd0;
      err_q        <= 1'b0;
      done_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      vreg_q       <= vreg_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      done_count_q <= done_count_d;
    end
  end

  // Next-state logic: accept only in IDLE, sequence the transfer, hold RESP until consumed.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    vreg_d       = vreg_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    done_count_d = done_count_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          addr_d = cmd_addr;
          vreg_d = cmd_vreg;
          err_d  = oob_s;
          if (oob_s) begin
            state_d = RESP;
          end else if (cmd_op) begin
            state_d = ST_RD;
          end else begin
            state_d = LD_REQ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LD_REQ: begin
        rdata_d = mem_out;
        state_d = LD_WB;
      end
      LD_WB:  state_d = RESP;
      ST_RD:  state_d = ST_WR;
      ST_WR:  state_d = RESP;
      RESP: begin
        if (resp_ready) begin
          done_count_d = done_count_q + 16'd1;
          state_d      = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the registered state; every address/data bus is zero when its strobe is low.
  always_comb begin
    cmd_ready         = 1'b0;
    resp_valid        = 1'b0;
    resp_err          = 1'b0;
    mem_read_enable   = 1'b0;
    mem_read_address  = 9'd0;
    mem_write_enable  = 1'b0;
    mem_write_address = 9'd0;
    mem_data          = 512'd0;
    vrf_re            = 1'b0;
    vrf_raddr         = '0;
    vrf_we            = 1'b0;
    vrf_waddr         = '0;
    vrf_wdata         = 512'd0;
    case (state_q)
      IDLE:   cmd_ready = 1'b1;
      LD_REQ: begin
        mem_read_enable  = 1'b1;
        mem_read_address = addr_q;
      end
      LD_WB: begin
        vrf_we    = 1'b1;
        vrf_waddr = vreg_q;
        vrf_wdata = rdata_q;
      end
      ST_RD: begin
        vrf_re    = 1'b1;
        vrf_raddr = vreg_q;
      end
      ST_WR: begin
        mem_write_enable  = 1'b1;
        mem_write_address = addr_q;
        mem_data          = vrf_rdata;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
      end
      default: cmd_ready = 1'b0;
    endcase
  end

  assign done_count = done_count_q;

  // op_q is kept for debug visibility of the in-flight command type.
  logic unused_s;
  assign unused_s = op_q;

endmodule
